// File: rtl/uart_pkg.sv
// Shared FSM encoding and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int NUM_REQ_DEFAULT    = 4;
  localparam int FRAME_BITS_DEFAULT = 10;

  // Index into a ring of n requesters; a may exceed n after adding an offset.
  function automatic int idx_wrap(input int a, input int n);
    return a % n;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning up from last_grant+1.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  // Walk the ring from farthest to nearest so the nearest requester overrides.
  always_comb begin
    valid  = 1'b0;
    winner = {IDX_W{1'b0}};
    onehot = {NUM_REQ{1'b0}};
    for (int k = NUM_REQ; k >= 1; k--) begin
      winner = req[idx_wrap(int'(last_grant) + k, NUM_REQ)]
             ? IDX_W'(idx_wrap(int'(last_grant) + k, NUM_REQ)) : winner;
      valid  = valid | req[idx_wrap(int'(last_grant) + k, NUM_REQ)];
    end
    onehot = valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : {NUM_REQ{1'b0}};
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: IDLE grants, LOAD waits for a
// bit tick while holding the start strobe, SEND counts out the frame.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 txenable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] reqData,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 transmit,
  output logic [7:0]           txData,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 transmit_q, transmit_d;
  logic [7:0]           txdata_q, txdata_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_q),
    .valid      (pick_valid),
    .winner     (pick_idx),
    .onehot     (pick_onehot)
  );

  // Next-state and output decode; grant is a single-clock pulse so it defaults low.
  always_comb begin
    state_d    = state_q;
    grant_d    = {NUM_REQ{1'b0}};
    transmit_d = transmit_q;
    txdata_d   = txdata_q;
    bitcnt_d   = bitcnt_q;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_LOAD;
          grant_d    = pick_onehot;
          transmit_d = 1'b1;
          txdata_d   = reqData[int'(pick_idx)*8 +: 8];
          last_d     = pick_idx;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (txenable) begin
          state_d    = ST_SEND;
          transmit_d = 1'b0;
          bitcnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d    = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (txenable && (bitcnt_q == FRAME_LAST)) begin
          state_d  = ST_IDLE;
          bitcnt_d = {CNT_W{1'b0}};
        end else if (txenable) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end else begin
          bitcnt_d = bitcnt_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        transmit_d = 1'b0;
        bitcnt_d   = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= {NUM_REQ{1'b0}};
      transmit_q <= 1'b0;
      txdata_q   <= 8'h00;
      busy_q     <= 1'b0;
      bitcnt_q   <= {CNT_W{1'b0}};
      last_q     <= LAST_RESET;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      transmit_q <= transmit_d;
      txdata_q   <= txdata_d;
      busy_q     <= busy_d;
      bitcnt_q   <= bitcnt_d;
      last_q     <= last_d;
    end
  end

  assign grant    = grant_q;
  assign transmit = transmit_q;
  assign txData   = txdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: NUM_REQ=4, FRAME_BITS=10, txenable every 4 clocks.
module tb_uart_tx_arbiter;

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        txenable = 1'b0;
  logic [3:0]  req      = 4'b0000;
  logic [31:0] req_data = 32'h0000_0000;
  logic [3:0]  grant;
  logic        transmit;
  logic [7:0]  txData;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int div         = 0;
  bit tick_run    = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .FRAME_BITS(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .txenable (txenable),
    .req      (req),
    .reqData  (req_data),
    .grant    (grant),
    .transmit (transmit),
    .txData   (txData),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Bit-rate tick: one clock high out of every four, updated on the falling edge.
  always @(negedge clock) begin
    if (tick_run) begin
      div      = (div == 3) ? 0 : div + 1;
      txenable = (div == 3);
    end else begin
      txenable = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      step();
      if (grant !== 4'b0000) begin
        g = grant;
        break;
      end
    end
  endtask

  // Called on the grant sample; runs until busy drops, measuring the frame.
  task automatic finish_frame(output int ticks, output int load_clks,
                              output logic [3:0] gseen, output bit stable);
    logic [7:0] d0;
    bit in_send;
    d0 = txData; ticks = 0; load_clks = 0; gseen = 4'b0000; stable = 1'b1; in_send = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      gseen = gseen | grant;
      if (txData !== d0) stable = 1'b0;
      if (!in_send) begin
        load_clks++;
        if (transmit === 1'b0) in_send = 1'b1;
      end else if (txenable === 1'b1) begin
        ticks++;
      end
      if (busy === 1'b0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    step();
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    vectors++; if (transmit !== 1'b0) begin miscompares++; $display("FAIL reset_transmit: got %b expected 0", transmit); end
    vectors++; if (txData !== 8'h00) begin miscompares++; $display("FAIL reset_txdata: got %h expected 00", txData); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    req = 4'b0000;
  endtask

  task automatic test_single();
    logic [3:0] g, gs; int ticks, lc; bit st;
    do_reset();
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    wait_grant(g);
    req = 4'b0000;
    vectors++; if (g !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b expected 0100", g); end
    vectors++; if (txData !== 8'hA5) begin miscompares++; $display("FAIL single_txdata: got %h expected a5", txData); end
    vectors++; if (transmit !== 1'b1) begin miscompares++; $display("FAIL single_transmit: got %b expected 1", transmit); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", busy); end
    finish_frame(ticks, lc, gs, st);
    vectors++; if (gs !== 4'b0000) begin miscompares++; $display("FAIL single_grant_width: extra grant %b expected 0000", gs); end
    vectors++; if (ticks !== 10) begin miscompares++; $display("FAIL single_ticks: got %0d expected 10", ticks); end
    vectors++; if (st !== 1'b1) begin miscompares++; $display("FAIL single_data_stable: got %b expected 1", st); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: busy %b expected 0", busy); end
    vectors++; if (txData !== 8'hA5) begin miscompares++; $display("FAIL single_txdata_hold: got %h expected a5", txData); end
  endtask

  task automatic test_round_robin();
    logic [3:0] g, gs; int ticks, lc; bit st;
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    exp_d[0] = 8'h11;   exp_d[1] = 8'h22;   exp_d[2] = 8'h33;   exp_d[3] = 8'h44;   exp_d[4] = 8'h11;
    do_reset();
    req_data = 32'h4433_2211;
    req = 4'b1111;
    wait_grant(g);
    vectors++; if (g !== exp_g[0]) begin miscompares++; $display("FAIL rr_grant0: got %b expected %b", g, exp_g[0]); end
    for (int k = 1; k < 5; k++) begin
      finish_frame(ticks, lc, gs, st);
      vectors++; if (ticks !== 10) begin miscompares++; $display("FAIL rr_ticks%0d: got %0d expected 10", k, ticks); end
      step();
      vectors++; if (grant !== exp_g[k]) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", k, grant, exp_g[k]); end
      vectors++; if (txData !== exp_d[k]) begin miscompares++; $display("FAIL rr_data%0d: got %h expected %h", k, txData, exp_d[k]); end
    end
    req = 4'b0000;
    finish_frame(ticks, lc, gs, st);
  endtask

  task automatic test_wrap_skip();
    logic [3:0] g, gs; int ticks, lc; bit st;
    do_reset();
    req = 4'b1000;
    wait_grant(g);
    vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL wrap_first: got %b expected 1000", g); end
    req = 4'b0101;
    finish_frame(ticks, lc, gs, st);
    vectors++; if (gs !== 4'b0000) begin miscompares++; $display("FAIL wrap_busy_grant: got %b expected 0000", gs); end
    step();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL wrap_second: got %b expected 0001", grant); end
    req = 4'b0100;
    finish_frame(ticks, lc, gs, st);
    step();
    vectors++; if (grant !== 4'b0100) begin miscompares++; $display("FAIL wrap_third: got %b expected 0100", grant); end
    req = 4'b0000;
    finish_frame(ticks, lc, gs, st);
  endtask

  task automatic test_busy_ignore();
    logic [3:0] g, gs, gacc; int ticks, lc; bit st; logic busy_any;
    do_reset();
    req = 4'b0001;
    wait_grant(g);
    req = 4'b0000;
    vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL ignore_grant: got %b expected 0001", g); end
    for (int i = 0; i < 50 && transmit !== 1'b0; i++) step();
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    finish_frame(ticks, lc, gs, st);
    gacc = 4'b0000; busy_any = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      gacc = gacc | grant;
      busy_any = busy_any | busy;
    end
    vectors++; if ((gs | gacc) !== 4'b0000) begin miscompares++; $display("FAIL ignore_no_grant: got %b expected 0000", gs | gacc); end
    vectors++; if (busy_any !== 1'b0) begin miscompares++; $display("FAIL ignore_stays_idle: busy %b expected 0", busy_any); end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] g, gs; int ticks, lc, n; bit st;
    do_reset();
    req = 4'b0001;
    wait_grant(g);
    req = 4'b0000;
    for (int i = 0; i < 50 && transmit !== 1'b0; i++) step();
    n = 0;
    for (int i = 0; i < 50 && n < 5; i++) begin
      step();
      if (txenable === 1'b1) n++;
    end
    reset = 1'b1;
    #1;
    vectors++; if (grant !== 4'b0000) begin miscompares++; $display("FAIL midrst_grant: got %b expected 0000", grant); end
    vectors++; if (transmit !== 1'b0) begin miscompares++; $display("FAIL midrst_transmit: got %b expected 0", transmit); end
    vectors++; if (txData !== 8'h00) begin miscompares++; $display("FAIL midrst_txdata: got %h expected 00", txData); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    step();
    step();
    reset = 1'b0;
    req = 4'b1010;
    wait_grant(g);
    req = 4'b0000;
    vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL midrst_regrant: got %b expected 0010", g); end
    finish_frame(ticks, lc, gs, st);
  endtask

  task automatic test_tick_coincidence();
    logic [3:0] gs; int ticks, lc; bit st;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      if (txenable === 1'b1) break;
    end
    req = 4'b0001;
    step();
    req = 4'b0000;
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL tick_grant: got %b expected 0001", grant); end
    vectors++; if (transmit !== 1'b1) begin miscompares++; $display("FAIL tick_transmit: got %b expected 1", transmit); end
    finish_frame(ticks, lc, gs, st);
    vectors++; if (lc !== 4) begin miscompares++; $display("FAIL tick_load_clocks: got %0d expected 4", lc); end
    vectors++; if (ticks !== 10) begin miscompares++; $display("FAIL tick_frame_ticks: got %0d expected 10", ticks); end
  endtask

  initial begin
    tick_run = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_busy_ignore();
    test_reset_mid_frame();
    test_tick_coincidence();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
